// File: rtl/mem_wb_pipe_if.sv
// MEM/WB stage handshake bundle.
//   Input side  (MEM -> stage): in_valid, in_ready, mem_data_in, alu_result_in, rd_in,
//                               we_rf_in, is_load_in
//   Output side (stage -> WB) : out_valid, out_ready, wb_data_out, rd_out, we_rf_out
// Modports:
//   slave  - the pipeline stage itself
//   master - the surroundings: the MEM producer and the WB consumer together
interface mem_wb_pipe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RA_W   = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [RA_W-1:0]   rd_in;
  logic              we_rf_in;
  logic              is_load_in;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data_out;
  logic [RA_W-1:0]   rd_out;
  logic              we_rf_out;

  modport master (
    output in_valid, mem_data_in, alu_result_in, rd_in, we_rf_in, is_load_in, out_ready,
    input  in_ready, out_valid, wb_data_out, rd_out, we_rf_out
  );

  modport slave (
    input  in_valid, mem_data_in, alu_result_in, rd_in, we_rf_in, is_load_in, out_ready,
    output in_ready, out_valid, wb_data_out, rd_out, we_rf_out
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage with valid/ready handshake, optional 2-entry skid buffer, synchronous
// flush and writeback-data select resolved at capture time.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      synchronous kill of all held entries (accept in the same cycle is dropped)
//   bus        mem_wb_pipe_if.slave: MEM-side input handshake and WB-side output handshake
//   occupancy  number of entries held (0..2, at most 1 when SKID_EN=0)
// Outputs are taken straight from the head (main) registers; the second (skid) entry only
// exists to absorb one transfer while in_ready, being registered, lags out_ready.
module mem_wb_pipe #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RA_W       = 3,
  parameter int unsigned SKID_EN    = 1,
  parameter int unsigned ZERO_GUARD = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  mem_wb_pipe_if.slave        bus,
  output logic [1:0]          occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [RA_W-1:0]   main_rd_q, main_rd_d;
  logic              main_we_q, main_we_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [RA_W-1:0]   skid_rd_q, skid_rd_d;
  logic              skid_we_q, skid_we_d;
  logic              in_ready_q, in_ready_d;

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] new_data;
  logic              new_we;

  assign out_valid = (state_q != StEmpty);

  // Without the skid entry, a full stage can only take a new entry while the head leaves.
  assign in_ready = (SKID_EN != 0) ? in_ready_q : (~out_valid | bus.out_ready);

  assign accept = bus.in_valid & in_ready;
  assign pop    = out_valid & bus.out_ready;

  // Writeback select and r0 guard are resolved once, at capture.
  assign new_data = bus.is_load_in ? bus.mem_data_in : bus.alu_result_in;
  assign new_we   = bus.we_rf_in & ~((ZERO_GUARD != 0) && (bus.rd_in == '0));

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_we_d   = main_we_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;

    if (flush) begin
      // A same-cycle pop is still consumed by WB; nothing survives either way.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            main_data_d = new_data;
            main_rd_d   = bus.rd_in;
            main_we_d   = new_we;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_data_d = new_data;
            main_rd_d   = bus.rd_in;
            main_we_d   = new_we;
          end else if (accept) begin
            // Only reachable with the skid entry present.
            state_d     = StFull;
            skid_data_d = new_data;
            skid_rd_d   = bus.rd_in;
            skid_we_d   = new_we;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d     = StOne;
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
            main_we_d   = skid_we_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_we_q   <= main_we_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.wb_data_out = main_data_q;
  assign bus.rd_out      = main_rd_q;
  // main_we_q keeps its value after a pop or flush; gate so an empty stage never writes.
  assign bus.we_rf_out   = main_we_q & out_valid;
  assign occupancy       = state_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: one instance with the skid buffer and one without share
// the same stimulus. Each has its own queue of expected entries; a recorder pushes accepted
// transfers, a monitor compares and pops on every WB consume.
module tb_mem_wb_pipe;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] rd;
    logic          we;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] mem_data_in = '0;
  logic [DW-1:0] alu_result_in = '0;
  logic [AW-1:0] rd_in = '0;
  logic          we_rf_in = 1'b0;
  logic          is_load_in = 1'b0;
  logic          out_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int pops [2] = '{0, 0};
  int base [2];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_wb_pipe_if #(.DATA_W(DW), .RA_W(AW)) bus ();
    logic [1:0] occ;
    item_t      q[$];
    logic       ready_m = 1'b1;

    assign bus.in_valid      = in_valid;
    assign bus.mem_data_in   = mem_data_in;
    assign bus.alu_result_in = alu_result_in;
    assign bus.rd_in         = rd_in;
    assign bus.we_rf_in      = we_rf_in;
    assign bus.is_load_in    = is_load_in;
    assign bus.out_ready     = out_ready;

    mem_wb_pipe #(
      .DATA_W(DW),
      .RA_W(AW),
      .SKID_EN(g),
      .ZERO_GUARD(1)
    ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .bus(bus),
      .occupancy(occ)
    );

    // Monitor: mid-cycle, after the edge and after the driver has settled this cycle's inputs.
    initial begin : monitor
      item_t h;
      forever begin
        @(negedge clk);
        ready_m = (g == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready);
        check($sformatf("skid%0d occupancy", g), 32'(occ), q.size());
        check($sformatf("skid%0d out_valid", g), 32'(bus.out_valid), 32'(q.size() != 0));
        check($sformatf("skid%0d in_ready", g), 32'(bus.in_ready), 32'(ready_m));
        if (q.size() != 0) begin
          h = q[0];
          check($sformatf("skid%0d wb_data_out", g), 32'(bus.wb_data_out), 32'(h.d));
          check($sformatf("skid%0d rd_out", g), 32'(bus.rd_out), 32'(h.rd));
          check($sformatf("skid%0d we_rf_out", g), 32'(bus.we_rf_out), 32'(h.we));
          if (out_ready) begin
            void'(q.pop_front());
            pops[g]++;
          end
        end else begin
          check($sformatf("skid%0d we_rf_out idle", g), 32'(bus.we_rf_out), 32'd0);
        end
      end
    end

    // Recorder: decides what the coming edge does to the reference queue.
    initial begin : recorder
      forever begin
        @(posedge clk);
        #7;
        if (rst || flush) q.delete();
        else if (in_valid && ready_m)
          q.push_back(item_t'{d: is_load_in ? mem_data_in : alu_result_in, rd: rd_in,
                              we: we_rf_in && (rd_in != 0)});
      end
    end

    initial begin : reset_watch
      forever begin
        @(posedge rst);
        q.delete();
        #1;
        check($sformatf("skid%0d rst out_valid", g), 32'(bus.out_valid), 32'd0);
        check($sformatf("skid%0d rst we_rf_out", g), 32'(bus.we_rf_out), 32'd0);
        check($sformatf("skid%0d rst occupancy", g), 32'(occ), 32'd0);
        check($sformatf("skid%0d rst in_ready", g), 32'(bus.in_ready), 32'd1);
        check($sformatf("skid%0d rst wb_data_out", g), 32'(bus.wb_data_out), 32'd0);
        check($sformatf("skid%0d rst rd_out", g), 32'(bus.rd_out), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                       input logic [AW-1:0] rd, input logic we, input logic ld,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid      = v;
    mem_data_in   = mem;
    alu_result_in = alu;
    rd_in         = rd;
    we_rf_in      = we;
    is_load_in    = ld;
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Writeback select: load picks memory data, otherwise ALU result.
    drive(1'b1, 8'hA5, 8'h3C, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'hA5, 8'h3C, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // r0 guard.
    drive(1'b1, 8'h11, 8'h22, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Back-pressure: 0x01, 0x02, 0x03 offered with WB stalled, then released.
    drive(1'b1, 8'h00, 8'h01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 8'h02, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 8'h03, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, 8'h00, 8'h03, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 4);

    // Flush while full with a competing accept of 0x77.
    drive(1'b1, 8'h00, 8'h10, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 8'h20, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 8'h77, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Asynchronous reset in the middle of traffic.
    drive(1'b1, 8'h5A, 8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h6B, 8'h00, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    idle(1'b1, 3);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 1500; i++)
      drive(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
    idle(1'b1, 4);

    // Throughput: 16 back-to-back transfers with WB always ready.
    base[0] = pops[0];
    base[1] = pops[1];
    for (int i = 0; i < 16; i++)
      drive(1'b1, 8'(i + 8'h80), 8'(i), 3'(i + 1), 1'b1, 1'(i % 2), 1'b1, 1'b0);
    idle(1'b1, 3);
    repeat (2) @(negedge clk);
    check("skid0 throughput", 32'(pops[0] - base[0]), 32'd16);
    check("skid1 throughput", 32'(pops[1] - base[1]), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
